// File: rtl/lt24_panel_rx.sv
// Panel-side responder for the LT24 8080-style bus: decodes ILI9341-subset commands,
// tracks the column/page window, streams RAMWR pixels and answers RDID reads.
module lt24_panel_rx #(
    parameter int H_RES       = 240,
    parameter int V_RES       = 320,
    parameter int SYNC_STAGES = 2
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic        lt24_cs_n_i,
    input  logic        lt24_wr_n_i,
    input  logic        lt24_rd_n_i,
    input  logic        lt24_rs_i,
    input  logic        lt24_reset_n_i,
    input  logic [15:0] lt24_d_i,
    output logic [15:0] lt24_d_o,
    output logic        lt24_d_oe_o,
    output logic        pix_we_o,
    output logic [8:0]  pix_x_o,
    output logic [8:0]  pix_y_o,
    output logic [15:0] pix_data_o,
    output logic        cmd_valid_o,
    output logic [7:0]  cmd_code_o,
    output logic        disp_on_o,
    output logic        sleep_o
);

    localparam logic [8:0] X_MAX = 9'(H_RES - 1);
    localparam logic [8:0] Y_MAX = 9'(V_RES - 1);

    typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, RDID} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0]       cs_sync, wr_sync, rd_sync, rs_sync, rst_sync;
    logic [SYNC_STAGES-1:0][15:0] d_sync;
    logic                         wr_prev, rd_prev;
    logic                         cs_s, wr_s, rd_s, rs_s, clr;
    logic [15:0]                  d_s;
    logic                         wr_evt, rd_evt, cmd_evt, dat_evt;

    logic [8:0]  xs, xe, ys, ye, x, y;
    logic [2:0]  param_cnt;
    logic [2:0]  id_idx;
    logic [7:0]  prm_start_hi, prm_start_lo, prm_end_hi;
    logic [17:0] win;

    // Limit end to the panel edge, then pull start down to end: returns {start, end}.
    function automatic logic [17:0] clamp_window(input logic [15:0] s, input logic [15:0] e,
                                                 input logic [8:0] lim);
        logic [8:0] e_c, s_c;
        e_c = (e > {7'd0, lim}) ? lim : e[8:0];
        s_c = (s > {7'd0, e_c}) ? e_c : s[8:0];
        return {s_c, e_c};
    endfunction

    function automatic logic [15:0] id_byte(input logic [2:0] idx);
        case (idx)
            3'd2:    return 16'h0093;
            3'd3:    return 16'h0041;
            default: return 16'h0000;
        endcase
    endfunction

    // Input synchronizers; d shares its depth with wr_n so data lines up with the strobe edge
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            cs_sync  <= '1;
            wr_sync  <= '1;
            rd_sync  <= '1;
            rs_sync  <= '0;
            rst_sync <= '1;
            d_sync   <= '0;
            wr_prev  <= 1'b1;
            rd_prev  <= 1'b1;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], lt24_cs_n_i};
            wr_sync  <= {wr_sync[SYNC_STAGES-2:0], lt24_wr_n_i};
            rd_sync  <= {rd_sync[SYNC_STAGES-2:0], lt24_rd_n_i};
            rs_sync  <= {rs_sync[SYNC_STAGES-2:0], lt24_rs_i};
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], lt24_reset_n_i};
            d_sync   <= {d_sync[SYNC_STAGES-2:0], lt24_d_i};
            wr_prev  <= wr_sync[SYNC_STAGES-1];
            rd_prev  <= rd_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s = cs_sync[SYNC_STAGES-1];
    assign wr_s = wr_sync[SYNC_STAGES-1];
    assign rd_s = rd_sync[SYNC_STAGES-1];
    assign rs_s = rs_sync[SYNC_STAGES-1];
    assign clr  = ~rst_sync[SYNC_STAGES-1];
    assign d_s  = d_sync[SYNC_STAGES-1];

    // A colliding read is dropped in favour of the write
    assign wr_evt  = wr_s & ~wr_prev & ~cs_s & ~clr;
    assign rd_evt  = ~rd_s & rd_prev & ~cs_s & ~clr & ~wr_evt;
    assign cmd_evt = wr_evt & ~rs_s;
    assign dat_evt = wr_evt & rs_s;
    assign win     = clamp_window({prm_start_hi, prm_start_lo}, {prm_end_hi, d_s[7:0]},
                                  (state == CASET) ? X_MAX : Y_MAX);

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) state <= IDLE;
        else if (clr)   state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cmd_evt) begin
            case (d_s[7:0])
                8'h2A:   state_nxt = CASET;
                8'h2B:   state_nxt = PASET;
                8'h2C:   state_nxt = RAMWR;
                8'hD3:   state_nxt = RDID;
                default: state_nxt = IDLE;
            endcase
        end else if (dat_evt && (state == CASET || state == PASET) && param_cnt == 3'd3) begin
            state_nxt = IDLE;
        end
    end

    // Parameter bytes are pure data; only the counter decides when they are consumed
    always_ff @(posedge mclk) begin
        if (dat_evt && (state == CASET || state == PASET)) begin
            case (param_cnt)
                3'd0:    prm_start_hi <= d_s[7:0];
                3'd1:    prm_start_lo <= d_s[7:0];
                3'd2:    prm_end_hi   <= d_s[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n || clr) begin
            xs          <= '0;
            xe          <= X_MAX;
            ys          <= '0;
            ye          <= Y_MAX;
            x           <= '0;
            y           <= '0;
            param_cnt   <= '0;
            id_idx      <= '0;
            pix_we_o    <= 1'b0;
            pix_x_o     <= '0;
            pix_y_o     <= '0;
            pix_data_o  <= '0;
            cmd_valid_o <= 1'b0;
            cmd_code_o  <= '0;
            disp_on_o   <= 1'b0;
            sleep_o     <= 1'b1;
            lt24_d_o    <= '0;
            lt24_d_oe_o <= 1'b0;
        end else begin
            pix_we_o    <= 1'b0;
            cmd_valid_o <= 1'b0;
            lt24_d_oe_o <= ~cs_s & ~rd_s & rs_s;
            if (cmd_evt) begin
                cmd_valid_o <= 1'b1;
                cmd_code_o  <= d_s[7:0];
                param_cnt   <= '0;
                case (d_s[7:0])
                    8'h01: begin
                        xs        <= '0;
                        xe        <= X_MAX;
                        ys        <= '0;
                        ye        <= Y_MAX;
                        disp_on_o <= 1'b0;
                        sleep_o   <= 1'b1;
                    end
                    8'h10: sleep_o   <= 1'b1;
                    8'h11: sleep_o   <= 1'b0;
                    8'h28: disp_on_o <= 1'b0;
                    8'h29: disp_on_o <= 1'b1;
                    8'h2C: begin
                        x <= xs;
                        y <= ys;
                    end
                    8'hD3: id_idx <= '0;
                    default: ;
                endcase
            end else if (dat_evt) begin
                case (state)
                    CASET, PASET: begin
                        if (param_cnt < 3'd4) param_cnt <= param_cnt + 3'd1;
                        if (param_cnt == 3'd3) begin
                            if (state == CASET) {xs, xe} <= win;
                            else                {ys, ye} <= win;
                        end
                    end
                    RAMWR: begin
                        pix_we_o   <= 1'b1;
                        pix_x_o    <= x;
                        pix_y_o    <= y;
                        pix_data_o <= d_s;
                        if (x == xe) begin
                            x <= xs;
                            y <= (y == ye) ? ys : y + 9'd1;
                        end else begin
                            x <= x + 9'd1;
                        end
                    end
                    default: ;
                endcase
            end
            if (rd_evt) begin
                lt24_d_o <= (state == RDID) ? id_byte(id_idx) : 16'h0000;
                if (state == RDID && id_idx != 3'd4) id_idx <= id_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_lt24_panel_rx.sv
// Directed bench for lt24_panel_rx: drives the 8080 bus pins and checks pixel,
// command, flag and ID read behaviour against hand-computed values.
module tb_lt24_panel_rx;

    logic        mclk = 1'b0;
    logic        puc_rst_n = 1'b0;
    logic        cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, rs = 1'b0, reset_n = 1'b1;
    logic [15:0] d = '0;
    logic [15:0] d_o;
    logic        d_oe, pix_we, cmd_valid, disp_on, sleep;
    logic [8:0]  pix_x, pix_y;
    logic [15:0] pix_data;
    logic [7:0]  cmd_code;

    int checks = 0;
    int errors = 0;

    // Pixel log filled by the monitor; tests compare entries past a saved base index
    int          pix_n = 0;
    logic [8:0]  log_x [256];
    logic [8:0]  log_y [256];
    logic [15:0] log_d [256];

    lt24_panel_rx #(.H_RES(240), .V_RES(320), .SYNC_STAGES(2)) dut (
        .mclk(mclk), .puc_rst_n(puc_rst_n), .lt24_cs_n_i(cs_n), .lt24_wr_n_i(wr_n),
        .lt24_rd_n_i(rd_n), .lt24_rs_i(rs), .lt24_reset_n_i(reset_n), .lt24_d_i(d),
        .lt24_d_o(d_o), .lt24_d_oe_o(d_oe), .pix_we_o(pix_we), .pix_x_o(pix_x),
        .pix_y_o(pix_y), .pix_data_o(pix_data), .cmd_valid_o(cmd_valid),
        .cmd_code_o(cmd_code), .disp_on_o(disp_on), .sleep_o(sleep)
    );

    always #5 mclk = ~mclk;

    always @(negedge mclk) begin
        if (pix_we) begin
            log_x[pix_n % 256] = pix_x;
            log_y[pix_n % 256] = pix_y;
            log_d[pix_n % 256] = pix_data;
            pix_n = pix_n + 1;
        end
    end

    task automatic bus_write(input logic r, input logic [15:0] v, input logic cs);
        @(posedge mclk); #1;
        cs_n = cs; rs = r; d = v; wr_n = 1'b0;
        repeat (4) @(posedge mclk);
        #1 wr_n = 1'b1;
        repeat (5) @(posedge mclk);
        #1 cs_n = 1'b0;
    endtask

    task automatic test_reset();
        puc_rst_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge mclk); #1;
            {cs_n, wr_n, rd_n, rs} = 4'($urandom);
            reset_n = 1'($urandom);
            d = 16'($urandom);
        end
        cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; rs = 1'b0; reset_n = 1'b1; d = '0;
        @(negedge mclk);
        checks++;
        if ({pix_we, cmd_valid, disp_on, d_oe} !== 4'b0000 || sleep !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: got we=%b cv=%b disp=%b oe=%b sleep=%b, want 0000 sleep=1",
                     pix_we, cmd_valid, disp_on, d_oe, sleep);
        end
        checks++;
        if ({pix_x, pix_y, pix_data, cmd_code, d_o} !== '0) begin
            errors++;
            $display("FAIL reset_buses: got x=%0d y=%0d pd=%h cmd=%h do=%h, want all 0",
                     pix_x, pix_y, pix_data, cmd_code, d_o);
        end
        checks++;
        if (pix_n !== 0) begin
            errors++;
            $display("FAIL reset_no_pix: got %0d pixel pulses, want 0", pix_n);
        end
        @(posedge mclk); #1 puc_rst_n = 1'b1;
        repeat (4) @(posedge mclk);
        #1 cs_n = 1'b0;
    endtask

    task automatic test_window_stream();
        logic [8:0] ex [7] = '{10, 11, 12, 10, 11, 12, 10};
        logic [8:0] ey [7] = '{5, 5, 5, 6, 6, 6, 5};
        int base;
        bus_write(0, 16'h002A, 0);
        checks++;
        if (cmd_code !== 8'h2A) begin
            errors++;
            $display("FAIL cmd_code_caset: got %h want 2a", cmd_code);
        end
        bus_write(1, 16'h0000, 0); bus_write(1, 16'h000A, 0);
        bus_write(1, 16'h0000, 0); bus_write(1, 16'h000C, 0);
        bus_write(0, 16'h002B, 0);
        bus_write(1, 16'h0000, 0); bus_write(1, 16'h0005, 0);
        bus_write(1, 16'h0000, 0); bus_write(1, 16'h0006, 0);
        bus_write(0, 16'h002C, 0);
        base = pix_n;
        for (int i = 0; i < 7; i++) bus_write(1, 16'hA000 + 16'(i), 0);
        checks++;
        if (pix_n - base !== 7) begin
            errors++;
            $display("FAIL stream_count: got %0d pixels want 7", pix_n - base);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (log_x[(base+i)%256] !== ex[i] || log_y[(base+i)%256] !== ey[i] ||
                log_d[(base+i)%256] !== 16'hA000 + 16'(i)) begin
                errors++;
                $display("FAIL stream_pix%0d: got (%0d,%0d) %h want (%0d,%0d) %h", i,
                         log_x[(base+i)%256], log_y[(base+i)%256], log_d[(base+i)%256],
                         ex[i], ey[i], 16'hA000 + 16'(i));
            end
        end
    endtask

    task automatic test_clamp();
        logic [8:0] ex [5] = '{238, 239, 238, 8, 8};
        logic [8:0] ey [5] = '{0, 0, 1, 0, 1};
        int base;
        base = pix_n;
        bus_write(0, 16'h002A, 0);
        bus_write(1, 16'h0000, 0); bus_write(1, 16'h00EE, 0);
        bus_write(1, 16'h0002, 0); bus_write(1, 16'h0000, 0);
        bus_write(0, 16'h002B, 0);
        bus_write(1, 16'h0000, 0); bus_write(1, 16'h0000, 0);
        bus_write(1, 16'h0000, 0); bus_write(1, 16'h0001, 0);
        bus_write(0, 16'h002C, 0);
        for (int i = 0; i < 3; i++) bus_write(1, 16'h1230 + 16'(i), 0);
        bus_write(0, 16'h002A, 0);
        bus_write(1, 16'h0000, 0); bus_write(1, 16'h0010, 0);
        bus_write(1, 16'h0000, 0); bus_write(1, 16'h0008, 0);
        bus_write(1, 16'h0055, 0);
        bus_write(0, 16'h002C, 0);
        for (int i = 3; i < 5; i++) bus_write(1, 16'h1230 + 16'(i), 0);
        checks++;
        if (pix_n - base !== 5) begin
            errors++;
            $display("FAIL clamp_count: got %0d pixels want 5", pix_n - base);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (log_x[(base+i)%256] !== ex[i] || log_y[(base+i)%256] !== ey[i]) begin
                errors++;
                $display("FAIL clamp_pix%0d: got (%0d,%0d) want (%0d,%0d)", i,
                         log_x[(base+i)%256], log_y[(base+i)%256], ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_partial_caset();
        int base;
        bus_write(0, 16'h002A, 0);
        bus_write(1, 16'h0000, 0); bus_write(1, 16'h0020, 0);
        bus_write(0, 16'h002C, 0);
        base = pix_n;
        bus_write(1, 16'hBEEF, 0); bus_write(1, 16'hCAFE, 0);
        checks++;
        if (pix_n - base !== 2 || log_x[base%256] !== 9'd8 || log_y[base%256] !== 9'd0 ||
            log_x[(base+1)%256] !== 9'd8 || log_y[(base+1)%256] !== 9'd1 ||
            log_d[(base+1)%256] !== 16'hCAFE) begin
            errors++;
            $display("FAIL partial_caset: got n=%0d (%0d,%0d) (%0d,%0d) %h want n=2 (8,0) (8,1) cafe",
                     pix_n - base, log_x[base%256], log_y[base%256],
                     log_x[(base+1)%256], log_y[(base+1)%256], log_d[(base+1)%256]);
        end
    endtask

    task automatic test_rdid();
        logic [15:0] exp_id [5] = '{16'h0000, 16'h0000, 16'h0093, 16'h0041, 16'h0000};
        bus_write(0, 16'h00D3, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge mclk); #1;
            rs = 1'b1; rd_n = 1'b0;
            repeat (4) @(posedge mclk);
            #1;
            checks++;
            if (d_oe !== 1'b1) begin
                errors++;
                $display("FAIL rdid_oe_low%0d: got %b want 1", i, d_oe);
            end
            rd_n = 1'b1;
            repeat (5) @(posedge mclk);
            #1;
            checks++;
            if (d_o !== exp_id[i] || d_oe !== 1'b0) begin
                errors++;
                $display("FAIL rdid_read%0d: got d_o=%h oe=%b want %h oe=0", i, d_o, d_oe, exp_id[i]);
            end
        end
    endtask

    task automatic test_flags();
        int base;
        bus_write(0, 16'h0029, 0);
        bus_write(0, 16'h0011, 0);
        checks++;
        if (disp_on !== 1'b1 || sleep !== 1'b0) begin
            errors++;
            $display("FAIL flags_on: got disp=%b sleep=%b want 1 0", disp_on, sleep);
        end
        bus_write(0, 16'h0001, 0);
        checks++;
        if (disp_on !== 1'b0 || sleep !== 1'b1 || cmd_code !== 8'h01) begin
            errors++;
            $display("FAIL flags_swreset: got disp=%b sleep=%b cmd=%h want 0 1 01", disp_on, sleep, cmd_code);
        end
        bus_write(0, 16'h002C, 0);
        base = pix_n;
        bus_write(1, 16'h0F0F, 0); bus_write(1, 16'hF0F0, 0);
        checks++;
        if (pix_n - base !== 2 || log_x[base%256] !== 9'd0 || log_y[base%256] !== 9'd0 ||
            log_x[(base+1)%256] !== 9'd1 || log_y[(base+1)%256] !== 9'd0) begin
            errors++;
            $display("FAIL swreset_window: got n=%0d (%0d,%0d) (%0d,%0d) want n=2 (0,0) (1,0)",
                     pix_n - base, log_x[base%256], log_y[base%256],
                     log_x[(base+1)%256], log_y[(base+1)%256]);
        end
    endtask

    task automatic test_panel_reset();
        int base;
        bus_write(0, 16'h0029, 0);
        bus_write(0, 16'h002C, 0);
        bus_write(1, 16'h7777, 0);
        @(posedge mclk); #1 reset_n = 1'b0;
        repeat (6) @(posedge mclk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge mclk);
        checks++;
        if (disp_on !== 1'b0 || sleep !== 1'b1 || cmd_code !== 8'h00) begin
            errors++;
            $display("FAIL panel_reset_flags: got disp=%b sleep=%b cmd=%h want 0 1 00", disp_on, sleep, cmd_code);
        end
        base = pix_n;
        for (int i = 0; i < 3; i++) bus_write(1, 16'h4440 + 16'(i), 0);
        checks++;
        if (pix_n - base !== 0) begin
            errors++;
            $display("FAIL panel_reset_idle: got %0d pixels want 0", pix_n - base);
        end
        bus_write(0, 16'h002C, 0);
        bus_write(1, 16'h5555, 0);
        bus_write(1, 16'h6666, 1);
        bus_write(1, 16'h7777, 0);
        checks++;
        if (pix_n - base !== 2 || log_x[base%256] !== 9'd0 ||
            log_x[(base+1)%256] !== 9'd1 || log_d[(base+1)%256] !== 16'h7777) begin
            errors++;
            $display("FAIL cs_gating: got n=%0d x0=%0d x1=%0d d1=%h want n=2 0 1 7777",
                     pix_n - base, log_x[base%256], log_x[(base+1)%256], log_d[(base+1)%256]);
        end
    endtask

    initial begin
        test_reset();
        test_window_stream();
        test_clamp();
        test_partial_caset();
        test_rdid();
        test_flags();
        test_panel_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
